// File: rtl/program_loader.sv
// UART boot loader: receives framed 8N1 bytes and writes 16-bit words into program RAM.
// Latency: write/ok/err strobes land one cycle after the byte that causes them; rx is 2-flop synchronised.
// Backpressure: none; the UART cannot be stalled, and pram writes are single-cycle fire-and-forget strobes.
module program_loader #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        clk_in,
    input  logic        reset_n,
    input  logic        rx,
    output logic [14:0] pram_addr,
    output logic [15:0] pram_data,
    output logic        pram_wren,
    output logic        init,
    output logic        load_ok,
    output logic        load_err
);

    localparam int CW        = $clog2(CLKS_PER_BIT);
    localparam int TO_CYCLES = 320 * CLKS_PER_BIT;
    localparam int TW        = $clog2(TO_CYCLES);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TO_CYCLES - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {
        F_IDLE, F_ADDR_LO, F_ADDR_HI, F_LEN, F_DATA_LO, F_DATA_HI, F_CSUM
    } fr_state_t;

    logic          rx_s1, rx_s2, rx_prev;
    rx_state_t     rx_state;
    logic [CW-1:0] clk_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    byte_dat;
    logic          byte_vld, frame_err;

    fr_state_t     fr_state, fr_next;
    logic [7:0]    addr_lo, data_lo, sum;
    logic [14:0]   word_addr;
    logic [8:0]    count;
    logic [TW-1:0] to_cnt;
    logic          timeout, abort;
    logic [7:0]    sum_next;
    logic          wr_go, ok_go, err_go, start_go;

    // Two-flop synchroniser plus one history flop for falling-edge detection; idle line is high.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    // UART receiver: half-bit start re-check, then 8 data bits and stop bit at full-bit spacing.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            rx_state  <= RX_IDLE;
            clk_cnt   <= '0;
            bit_idx   <= '0;
            byte_dat  <= '0;
            byte_vld  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            byte_vld  <= 1'b0;
            frame_err <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    clk_cnt <= '0;
                    if (rx_prev && !rx_s2) rx_state <= RX_START;
                end
                RX_START: begin
                    if (clk_cnt == HALF_LAST) begin
                        clk_cnt <= '0;
                        bit_idx <= '0;
                        // A high line here was a glitch, not a start bit.
                        rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt  <= '0;
                        byte_dat <= {rx_s2, byte_dat[7:1]};
                        bit_idx  <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) rx_state <= RX_STOP;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt   <= '0;
                        rx_state  <= RX_IDLE;
                        byte_vld  <= rx_s2;
                        frame_err <= !rx_s2;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    assign sum_next = sum + byte_dat;
    assign timeout  = (fr_state != F_IDLE) && !byte_vld && (to_cnt == TO_LAST);
    // Line errors and silence only matter once a frame has started.
    assign abort    = (fr_state != F_IDLE) && (frame_err || timeout);

    // Frame state register.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) fr_state <= F_IDLE;
        else          fr_state <= fr_next;
    end

    // Frame next-state decode, advancing one state per received byte.
    always_comb begin
        fr_next = fr_state;
        if (abort) begin
            fr_next = F_IDLE;
        end else if (byte_vld) begin
            case (fr_state)
                F_IDLE:    if (byte_dat == 8'hA5) fr_next = F_ADDR_LO;
                F_ADDR_LO: fr_next = F_ADDR_HI;
                F_ADDR_HI: fr_next = F_LEN;
                F_LEN:     fr_next = F_DATA_LO;
                F_DATA_LO: fr_next = F_DATA_HI;
                F_DATA_HI: fr_next = (count == 9'd1) ? F_CSUM : F_DATA_LO;
                F_CSUM:    fr_next = F_IDLE;
                default:   fr_next = F_IDLE;
            endcase
        end
    end

    // Frame output decode: which strobes fire on this cycle's byte or abort.
    always_comb begin
        start_go = byte_vld && (fr_state == F_IDLE) && (byte_dat == 8'hA5);
        wr_go    = byte_vld && (fr_state == F_DATA_HI);
        ok_go    = byte_vld && (fr_state == F_CSUM) && (sum_next == 8'h00);
        err_go   = abort || (byte_vld && (fr_state == F_CSUM) && (sum_next != 8'h00));
    end

    // Frame datapath: address/count/checksum tracking and registered RAM and status outputs.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            pram_addr <= '0;
            pram_data <= '0;
            pram_wren <= 1'b0;
            init      <= 1'b1;
            load_ok   <= 1'b0;
            load_err  <= 1'b0;
            addr_lo   <= '0;
            data_lo   <= '0;
            sum       <= '0;
            word_addr <= '0;
            count     <= '0;
            to_cnt    <= '0;
        end else begin
            pram_wren <= wr_go;
            load_ok   <= ok_go;
            load_err  <= err_go;
            if (start_go)     init <= 1'b1;
            else if (ok_go)   init <= 1'b0;
            if (start_go)                               sum <= '0;
            else if (byte_vld && fr_state != F_IDLE)    sum <= sum_next;
            if (fr_state == F_IDLE || byte_vld) to_cnt <= '0;
            else if (to_cnt != TO_LAST)         to_cnt <= to_cnt + 1'b1;
            if (byte_vld) begin
                case (fr_state)
                    F_ADDR_LO: addr_lo   <= byte_dat;
                    // Byte address bit 0 is dropped: RAM is word addressed.
                    F_ADDR_HI: word_addr <= {byte_dat, addr_lo[7:1]};
                    F_LEN:     count     <= (byte_dat == 8'h00) ? 9'd256 : {1'b0, byte_dat};
                    F_DATA_LO: data_lo   <= byte_dat;
                    F_DATA_HI: begin
                        pram_addr <= word_addr;
                        pram_data <= {byte_dat, data_lo};
                        word_addr <= word_addr + 15'd1;
                        count     <= count - 9'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader with CLKS_PER_BIT=4.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_program_loader;
    localparam int CPB = 4;

    logic        clk_in = 1'b0;
    logic        reset_n = 1'b0;
    logic        rx = 1'b1;
    logic [14:0] pram_addr;
    logic [15:0] pram_data;
    logic        pram_wren;
    logic        init;
    logic        load_ok;
    logic        load_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ok_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;
    int err_cyc = 0;
    logic [14:0] wa_q[$];
    logic [15:0] wd_q[$];
    logic [7:0]  frm[$];

    program_loader #(.CLKS_PER_BIT(CPB)) dut (
        .clk_in(clk_in), .reset_n(reset_n), .rx(rx),
        .pram_addr(pram_addr), .pram_data(pram_data), .pram_wren(pram_wren),
        .init(init), .load_ok(load_ok), .load_err(load_err)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc++;

    // Observe strobes away from the active edge.
    always @(negedge clk_in) begin
        if (pram_wren) begin
            wa_q.push_back(pram_addr);
            wd_q.push_back(pram_data);
        end
        if (load_ok) ok_cnt++;
        if (load_err) begin
            err_cnt++;
            err_cyc = cyc;
        end
        if (load_ok && load_err) both_cnt++;
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        idle(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            idle(CPB);
        end
        rx = stop;
        idle(CPB);
        rx = 1'b1;
    endtask

    task automatic send_frm();
        for (int i = 0; i < frm.size(); i++) send_byte(frm[i], 1'b1);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        rx = 1'b1;
        idle(3);
        if (init !== 1'b1) begin errors++; $display("FAIL reset_init: got %b want 1", init); end checks++;
        if (pram_wren !== 1'b0) begin errors++; $display("FAIL reset_wren: got %b want 0", pram_wren); end checks++;
        if (load_ok !== 1'b0) begin errors++; $display("FAIL reset_ok: got %b want 0", load_ok); end checks++;
        if (load_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", load_err); end checks++;
        if (pram_addr !== 15'h0) begin errors++; $display("FAIL reset_addr: got %h want 0000", pram_addr); end checks++;
        if (pram_data !== 16'h0) begin errors++; $display("FAIL reset_data: got %h want 0000", pram_data); end checks++;
        reset_n = 1'b1;
        idle(10);
        if (init !== 1'b1) begin errors++; $display("FAIL post_reset_init: got %b want 1", init); end checks++;
    endtask

    task automatic test_good_frame();
        int wb, ob, eb;
        wb = wa_q.size(); ob = ok_cnt; eb = err_cnt;
        frm = '{8'hA5, 8'h00, 8'h01, 8'h02, 8'h34, 8'h12, 8'h78, 8'h56, 8'hE9};
        send_frm();
        idle(20);
        if (wa_q.size() - wb != 2) begin errors++; $display("FAIL good_nwr: got %0d want 2", wa_q.size() - wb); end checks++;
        if (wa_q[wb] !== 15'h0080) begin errors++; $display("FAIL good_a0: got %h want 0080", wa_q[wb]); end checks++;
        if (wd_q[wb] !== 16'h1234) begin errors++; $display("FAIL good_d0: got %h want 1234", wd_q[wb]); end checks++;
        if (wa_q[wb+1] !== 15'h0081) begin errors++; $display("FAIL good_a1: got %h want 0081", wa_q[wb+1]); end checks++;
        if (wd_q[wb+1] !== 16'h5678) begin errors++; $display("FAIL good_d1: got %h want 5678", wd_q[wb+1]); end checks++;
        if (ok_cnt - ob != 1) begin errors++; $display("FAIL good_ok: got %0d want 1", ok_cnt - ob); end checks++;
        if (err_cnt - eb != 0) begin errors++; $display("FAIL good_err: got %0d want 0", err_cnt - eb); end checks++;
        if (init !== 1'b0) begin errors++; $display("FAIL good_init: got %b want 0", init); end checks++;
        if (pram_addr !== 15'h0081) begin errors++; $display("FAIL good_addr_hold: got %h want 0081", pram_addr); end checks++;
        if (pram_data !== 16'h5678) begin errors++; $display("FAIL good_data_hold: got %h want 5678", pram_data); end checks++;
    endtask

    task automatic test_bad_csum();
        int wb, ob, eb;
        wb = wa_q.size(); ob = ok_cnt; eb = err_cnt;
        frm = '{8'hA5, 8'h00, 8'h01, 8'h02, 8'h34, 8'h12, 8'h78, 8'h56, 8'h00};
        send_frm();
        idle(20);
        if (wa_q.size() - wb != 2) begin errors++; $display("FAIL bad_nwr: got %0d want 2", wa_q.size() - wb); end checks++;
        if (wd_q[wb+1] !== 16'h5678) begin errors++; $display("FAIL bad_d1: got %h want 5678", wd_q[wb+1]); end checks++;
        if (ok_cnt - ob != 0) begin errors++; $display("FAIL bad_ok: got %0d want 0", ok_cnt - ob); end checks++;
        if (err_cnt - eb != 1) begin errors++; $display("FAIL bad_err: got %0d want 1", err_cnt - eb); end checks++;
        if (init !== 1'b1) begin errors++; $display("FAIL bad_init: got %b want 1", init); end checks++;
    endtask

    task automatic test_addr_wrap();
        int wb, ob;
        wb = wa_q.size(); ob = ok_cnt;
        frm = '{8'hA5, 8'hFE, 8'hFF, 8'h02, 8'h00, 8'h01, 8'h00, 8'h02, 8'hFE};
        send_frm();
        idle(20);
        if (wa_q.size() - wb != 2) begin errors++; $display("FAIL wrap_nwr: got %0d want 2", wa_q.size() - wb); end checks++;
        if (wa_q[wb] !== 15'h7FFF) begin errors++; $display("FAIL wrap_a0: got %h want 7fff", wa_q[wb]); end checks++;
        if (wd_q[wb] !== 16'h0100) begin errors++; $display("FAIL wrap_d0: got %h want 0100", wd_q[wb]); end checks++;
        if (wa_q[wb+1] !== 15'h0000) begin errors++; $display("FAIL wrap_a1: got %h want 0000", wa_q[wb+1]); end checks++;
        if (wd_q[wb+1] !== 16'h0200) begin errors++; $display("FAIL wrap_d1: got %h want 0200", wd_q[wb+1]); end checks++;
        if (ok_cnt - ob != 1) begin errors++; $display("FAIL wrap_ok: got %0d want 1", ok_cnt - ob); end checks++;
        if (init !== 1'b0) begin errors++; $display("FAIL wrap_init: got %b want 0", init); end checks++;
    endtask

    task automatic test_noise();
        int wb, ob, eb;
        wb = wa_q.size(); ob = ok_cnt; eb = err_cnt;
        rx = 1'b0;
        idle(1);
        rx = 1'b1;
        idle(20);
        send_byte(8'h55, 1'b1);
        send_byte(8'h02, 1'b1);
        idle(20);
        if (wa_q.size() - wb != 0) begin errors++; $display("FAIL noise_nwr: got %0d want 0", wa_q.size() - wb); end checks++;
        if (ok_cnt - ob != 0) begin errors++; $display("FAIL noise_ok: got %0d want 0", ok_cnt - ob); end checks++;
        if (err_cnt - eb != 0) begin errors++; $display("FAIL noise_err: got %0d want 0", err_cnt - eb); end checks++;
        if (init !== 1'b0) begin errors++; $display("FAIL noise_init: got %b want 0", init); end checks++;
    endtask

    task automatic test_frame_err();
        int wb, ob, eb;
        wb = wa_q.size(); ob = ok_cnt; eb = err_cnt;
        frm = '{8'hA5, 8'h00, 8'h01, 8'h02, 8'h34};
        send_frm();
        send_byte(8'h12, 1'b0);
        idle(20);
        if (err_cnt - eb != 1) begin errors++; $display("FAIL ferr_err: got %0d want 1", err_cnt - eb); end checks++;
        frm = '{8'h78, 8'h56, 8'h34, 8'h12};
        send_frm();
        idle(20);
        if (wa_q.size() - wb != 0) begin errors++; $display("FAIL ferr_nwr: got %0d want 0", wa_q.size() - wb); end checks++;
        if (ok_cnt - ob != 0) begin errors++; $display("FAIL ferr_ok: got %0d want 0", ok_cnt - ob); end checks++;
        if (err_cnt - eb != 1) begin errors++; $display("FAIL ferr_err_once: got %0d want 1", err_cnt - eb); end checks++;
        if (init !== 1'b1) begin errors++; $display("FAIL ferr_init: got %b want 1", init); end checks++;
    endtask

    task automatic test_timeout();
        int eb, t0, waited, lat;
        eb = err_cnt;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        t0 = cyc;
        waited = 0;
        while (err_cnt == eb && waited < 1500) begin
            idle(1);
            waited++;
        end
        if (err_cnt - eb != 1) begin errors++; $display("FAIL tmo_err: got %0d want 1 within 1500 cycles", err_cnt - eb); end checks++;
        lat = err_cyc - t0;
        if (lat < 1270 || lat > 1295) begin errors++; $display("FAIL tmo_latency: got %0d want about 1280", lat); end checks++;
        idle(20);
        if (err_cnt - eb != 1) begin errors++; $display("FAIL tmo_err_once: got %0d want 1", err_cnt - eb); end checks++;
    endtask

    task automatic test_reset_mid();
        int wb, ob;
        wb = wa_q.size(); ob = ok_cnt;
        frm = '{8'hA5, 8'h00, 8'h01, 8'h02, 8'h34, 8'h12};
        send_frm();
        idle(3);
        if (wa_q.size() - wb != 1) begin errors++; $display("FAIL rstm_first_wr: got %0d want 1", wa_q.size() - wb); end checks++;
        reset_n = 1'b0;
        #1;
        if (pram_addr !== 15'h0) begin errors++; $display("FAIL rstm_addr: got %h want 0000", pram_addr); end checks++;
        if (pram_data !== 16'h0) begin errors++; $display("FAIL rstm_data: got %h want 0000", pram_data); end checks++;
        if (pram_wren !== 1'b0) begin errors++; $display("FAIL rstm_wren: got %b want 0", pram_wren); end checks++;
        if (init !== 1'b1) begin errors++; $display("FAIL rstm_init: got %b want 1", init); end checks++;
        idle(3);
        reset_n = 1'b1;
        idle(5);
        frm = '{8'h78, 8'h56, 8'hE9};
        send_frm();
        idle(20);
        if (wa_q.size() - wb != 1) begin errors++; $display("FAIL rstm_no_wr: got %0d want 1", wa_q.size() - wb); end checks++;
        if (ok_cnt - ob != 0) begin errors++; $display("FAIL rstm_no_ok: got %0d want 0", ok_cnt - ob); end checks++;
        wb = wa_q.size();
        frm = '{8'hA5, 8'h00, 8'h01, 8'h02, 8'h34, 8'h12, 8'h78, 8'h56, 8'hE9};
        send_frm();
        idle(20);
        if (wa_q.size() - wb != 2) begin errors++; $display("FAIL rstm_reload_nwr: got %0d want 2", wa_q.size() - wb); end checks++;
        if (wa_q[wb] !== 15'h0080) begin errors++; $display("FAIL rstm_reload_a0: got %h want 0080", wa_q[wb]); end checks++;
        if (ok_cnt - ob != 1) begin errors++; $display("FAIL rstm_reload_ok: got %0d want 1", ok_cnt - ob); end checks++;
        if (init !== 1'b0) begin errors++; $display("FAIL rstm_reload_init: got %b want 0", init); end checks++;
    endtask

    task automatic test_exclusive();
        if (both_cnt != 0) begin errors++; $display("FAIL ok_err_same_cycle: got %0d want 0", both_cnt); end checks++;
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_csum();
        test_addr_wrap();
        test_noise();
        test_frame_err();
        test_timeout();
        test_reset_mid();
        test_exclusive();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL provide parameter CLKS_PER_BIT, default 434, meaning clk_in cycles per UART bit; legal values are 4 or more.
REQ-002 SHALL provide port clk_in, input, 1 bit, the 50 MHz clock; it is the only clock.
REQ-003 SHALL provide port reset_n, input, 1 bit; reset is asynchronous and active-low.
REQ-004 SHALL provide port rx, input, 1 bit, the UART serial line: 8N1, LSB first, idle high.
REQ-005 SHALL provide port pram_addr, output, 15 bits, the program RAM word address.
REQ-006 SHALL provide port pram_data, output, 16 bits, the program RAM write data.
REQ-007 SHALL provide port pram_wren, output, 1 bit, a one-cycle write strobe.
REQ-008 SHALL provide port init, output, 1 bit; while high, the CPU is held in init mode.
REQ-009 SHALL provide port load_ok, output, 1 bit, a one-cycle pulse when a frame is accepted.
REQ-010 SHALL provide port load_err, output, 1 bit, a one-cycle pulse when a frame is aborted.

Function
REQ-011 SHALL pass rx through a 2-flop synchronizer; both flops reset to 1.
REQ-012 SHALL detect a start bit as a synchronized falling edge while the receiver is idle.
REQ-013 SHALL re-sample the start bit CLKS_PER_BIT/2 cycles after the edge; if it is high, the receiver returns to idle and emits no byte.
REQ-014 SHALL sample 8 data bits, then the stop bit, each CLKS_PER_BIT cycles apart.
REQ-015 SHALL emit a one-cycle internal byte_valid on the cycle after a stop sample of 1.
REQ-016 SHALL treat a stop sample of 0 as a framing error; the byte is discarded.
REQ-017 SHALL implement frame states IDLE, ADDR_LO, ADDR_HI, LEN, DATA_LO, DATA_HI, CSUM.
- IDLE: leaves only on byte 0xA5; all other bytes are ignored.
- 0xA5 accepted: init=1, running sum=0, next state ADDR_LO.
REQ-018 SHALL form the byte address from ADDR_LO then ADDR_HI; start word address = byte_addr[15:1], and bit 0 is ignored.
REQ-019 SHALL load the LEN byte as the word count, where 0 means 256.
REQ-020 SHALL handle each data word as follows:
- DATA_LO then DATA_HI.
- On the DATA_HI byte, next cycle: pram_wren=1 for exactly 1 cycle, pram_data={hi,lo}, pram_addr=current word address.
- Word address then increments mod 2^15 (0x7FFF wraps to 0x0000).
- Count decrements; count 0 moves to CSUM, otherwise back to DATA_LO.
REQ-021 SHALL hold pram_addr and pram_data stable between strobes.
REQ-022 SHALL compute the checksum as the 8-bit sum of all bytes after 0xA5, including the CSUM byte.
- Sum == 0x00: load_ok pulse, init=0 on the same cycle.
- Otherwise: load_err pulse, init stays 1.
- Either way, next state is IDLE.
REQ-023 SHALL NOT undo writes already issued in a failed frame; init stays high so the CPU cannot run a corrupt image.
REQ-024 SHALL pulse load_err, return to IDLE, and issue no further writes on a framing error outside IDLE.
REQ-025 SHALL ignore framing errors while in IDLE.
REQ-026 SHALL abort a frame when it sees no byte_valid for 320*CLKS_PER_BIT cycles outside IDLE: load_err pulse, then IDLE.
REQ-027 SHALL never assert load_ok and load_err on the same cycle.
REQ-028 SHALL leave init unchanged when a new 0xA5 arrives in IDLE with init already 0 until that byte is accepted, then set init=1.

Reset
REQ-029 SHALL apply reset asynchronously on reset_n low, with the following values:
- init=1.
- pram_wren=0, load_ok=0, load_err=0.
- pram_addr=0, pram_data=0.
- Frame FSM in IDLE, receiver idle, timeout counter cleared.
REQ-030 SHALL abandon any frame in progress on reset without further writes.

Verification (CLKS_PER_BIT=4)
REQ-031 SHALL cover a good frame:
- Stimulus: A5 00 01 02 34 12 78 56 E9.
- Response: writes 0x080=0x1234 and 0x081=0x5678, then load_ok, then init=0.
REQ-032 SHALL cover a bad checksum:
- Stimulus: the REQ-031 frame with last byte 00.
- Response: the same two writes, then load_err, init=1.
REQ-033 SHALL cover address wrap:
- Stimulus: A5 FE FF 02 00 01 00 02 FE.
- Response: writes 0x7FFF=0x0100 and 0x0000=0x0200, then load_ok.
REQ-034 SHALL cover noise and a stray byte in IDLE:
- Stimulus: a 1-cycle rx low, then byte 55.
- Response: no write, no pulses, state IDLE.
REQ-035 SHALL cover a framing error:
- Stimulus: stop bit 0 on the first DATA_HI byte.
- Response: load_err, no write.
- Then: timeout after A5 00 → load_err 320*4 cycles after the last byte.
REQ-036 SHALL cover reset mid-frame:
- Stimulus: reset_n low after the first write, then the REQ-031 frame.
- Response: reset values immediately, then a normal load.
